// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared encodings and helpers for the load/store unit
// Contents: funct3 encodings, FSM state type, bus write-enable levels,
// and funct3 decode helpers used by mem_lsu and mem_lsu_fmt.
package mem_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [63:0] ZERO_WORD    = 64'd0;
  localparam logic        READ_ENABLE  = 1'b0;
  localparam logic        WRITE_ENABLE = 1'b1;

  // funct3 values that name no access at this data width.
  function automatic logic f3_invalid(input logic [2:0] f3, input logic is_store, input int data_w);
    logic w64;
    w64 = (data_w == 64);
    if (is_store) return f3[2] || (!w64 && f3 == F3_SD);
    return (f3 == 3'b111) || (!w64 && (f3 == F3_LD || f3 == F3_LWU));
  endfunction

  // log2 of the access size in bytes; invalid encodings become full-width.
  function automatic logic [1:0] size_log2(input logic [2:0] f3, input logic is_store, input int data_w);
    if (f3_invalid(f3, is_store, data_w)) return (data_w == 64) ? 2'd3 : 2'd2;
    return f3[1:0];
  endfunction

endpackage

// File: rtl/mem_lsu_fmt.sv
// rtl/mem_lsu_fmt.sv - combinational lane alignment and load formatting
// Ports:
//   funct3, store, addr, wdata   request-side instruction fields
//   bus_addr, be, bus_wdata      word-aligned address, byte enables, replicated store data
//   off                          naturally aligned lane offset to remember for the response
//   misalign                     unaligned access or invalid funct3
//   rsp_funct3, rsp_off, rdata   latched load info plus raw bus read word
//   load_data                    extracted and sign/zero-extended load result
module mem_lsu_fmt
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic [2:0]                       funct3,
  input  logic                             store,
  input  logic [ADDR_W-1:0]                addr,
  input  logic [DATA_W-1:0]                wdata,
  output logic [ADDR_W-1:0]                bus_addr,
  output logic [DATA_W/8-1:0]              be,
  output logic [DATA_W-1:0]                bus_wdata,
  output logic [$clog2(DATA_W/8)-1:0]      off,
  output logic                             misalign,
  input  logic [2:0]                       rsp_funct3,
  input  logic [$clog2(DATA_W/8)-1:0]      rsp_off,
  input  logic [DATA_W-1:0]                rdata,
  output logic [DATA_W-1:0]                load_data
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  logic [1:0]       sz;
  logic [OFF_W-1:0] raw_off;
  logic [OFF_W-1:0] size_mask;

  always_comb begin
    sz        = size_log2(funct3, store, DATA_W);
    raw_off   = addr[OFF_W-1:0];
    size_mask = OFF_W'((1 << sz) - 1);
    // Low offset bits below the access size are dropped: natural alignment.
    off       = raw_off & ~size_mask;
    misalign  = f3_invalid(funct3, store, DATA_W) || ((raw_off & size_mask) != '0);
    bus_addr  = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    be        = NB'((1 << (1 << sz)) - 1) << off;
    bus_wdata = '0;
    // Each lane takes the store byte at its position modulo the access size.
    for (int i = 0; i < NB; i++) begin
      bus_wdata[8*i +: 8] = wdata[8*(i & ((1 << sz) - 1)) +: 8];
    end
  end

  logic [1:0]        rsz;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] left;
  int                pad;

  always_comb begin
    rsz     = size_log2(rsp_funct3, 1'b0, DATA_W);
    shifted = rdata >> (8 * rsp_off);
    pad     = DATA_W - (8 << rsz);
    // Park the field at the top, then shift back down logically or arithmetically.
    left    = shifted << pad;
    if (rsp_funct3[2]) load_data = left >> pad;
    else               load_data = DATA_W'($signed(left) >>> pad);
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store memory stage between EX and WB
// Optional feature macro: MEM_LSU_MISALIGN_TRAP_EN (misaligned/invalid accesses
// skip the bus and retire with misalign_o=1).
// Ports:
//   clk, arst_n                      clock, synchronous active-low reset
//   valid_i/ready_o                  EX handshake; load_i, store_i, funct3_i, addr_i, wdata_i
//   reg_w_ena_i/addr_i/data_i        ALU writeback from EX
//   dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, dmem_ack_i, dmem_rdata_i  data bus
//   valid_o/ready_i                  WB handshake; reg_w_ena_o/addr_o/data_o, misalign_o results
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  load_i,
  input  logic                  store_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  reg_w_ena_i,
  input  logic [4:0]            reg_w_addr_i,
  input  logic [DATA_W-1:0]     reg_w_data_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_W-1:0]     dmem_addr_o,
  output logic [DATA_W/8-1:0]   dmem_be_o,
  output logic [DATA_W-1:0]     dmem_wdata_o,
  input  logic                  dmem_ack_i,
  input  logic [DATA_W-1:0]     dmem_rdata_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  reg_w_ena_o,
  output logic [4:0]            reg_w_addr_o,
  output logic [DATA_W-1:0]     reg_w_data_o,
  output logic                  misalign_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_t           state;
  logic [2:0]       rsp_funct3;
  logic [OFF_W-1:0] rsp_off;
  logic             is_load;
  logic [4:0]       rd;
  logic             rd_wr;

  logic [ADDR_W-1:0] f_addr;
  logic [NB-1:0]     f_be;
  logic [DATA_W-1:0] f_wdata;
  logic [OFF_W-1:0]  f_off;
  logic              f_misalign;
  logic [DATA_W-1:0] f_load_data;

  mem_lsu_fmt #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fmt (
    .funct3     (funct3_i),
    .store      (store_i),
    .addr       (addr_i),
    .wdata      (wdata_i),
    .bus_addr   (f_addr),
    .be         (f_be),
    .bus_wdata  (f_wdata),
    .off        (f_off),
    .misalign   (f_misalign),
    .rsp_funct3 (rsp_funct3),
    .rsp_off    (rsp_off),
    .rdata      (dmem_rdata_i),
    .load_data  (f_load_data)
  );

  logic accept;
  logic is_mem;
  logic trap;

  assign ready_o = (state == ST_IDLE) && (!valid_o || ready_i);
  assign accept  = valid_i && ready_o;
  assign is_mem  = load_i || store_i;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  assign trap = f_misalign;
`else
  logic unused_misalign;
  assign trap            = 1'b0;
  assign unused_misalign = f_misalign;
  assign misalign_o      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state        <= ST_IDLE;
      valid_o      <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= READ_ENABLE;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= ZERO_WORD[DATA_W-1:0];
      reg_w_ena_o  <= 1'b0;
      reg_w_addr_o <= '0;
      reg_w_data_o <= ZERO_WORD[DATA_W-1:0];
      rsp_funct3   <= '0;
      rsp_off      <= '0;
      is_load      <= 1'b0;
      rd           <= '0;
      rd_wr        <= 1'b0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
      misalign_o   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (ready_i) valid_o <= 1'b0;
          if (accept) begin
            if (!is_mem) begin
              valid_o      <= 1'b1;
              reg_w_ena_o  <= reg_w_ena_i;
              reg_w_addr_o <= reg_w_addr_i;
              reg_w_data_o <= reg_w_data_i;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
              misalign_o   <= 1'b0;
`endif
            end else begin
              valid_o      <= 1'b0;
              reg_w_ena_o  <= 1'b0;
              reg_w_addr_o <= '0;
              reg_w_data_o <= '0;
              is_load      <= load_i;
              rd           <= reg_w_addr_i;
              // x0 loads still touch the bus but never write back.
              rd_wr        <= load_i && reg_w_ena_i && (reg_w_addr_i != 5'd0);
              rsp_funct3   <= funct3_i;
              rsp_off      <= f_off;
              if (trap) begin
                state        <= ST_DONE;
                valid_o      <= 1'b1;
                reg_w_addr_o <= reg_w_addr_i;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
                misalign_o   <= 1'b1;
`endif
              end else begin
                state        <= ST_BUS;
                dmem_req_o   <= 1'b1;
                dmem_we_o    <= store_i ? WRITE_ENABLE : READ_ENABLE;
                dmem_addr_o  <= f_addr;
                dmem_be_o    <= f_be;
                dmem_wdata_o <= f_wdata;
              end
            end
          end
        end
        ST_BUS: begin
          if (dmem_ack_i) begin
            state        <= ST_DONE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= READ_ENABLE;
            valid_o      <= 1'b1;
            reg_w_ena_o  <= rd_wr;
            reg_w_addr_o <= rd;
            reg_w_data_o <= is_load ? f_load_data : '0;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            state   <= ST_IDLE;
            valid_o <= 1'b0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - self-checking bench for mem_lsu (DATA_W=32)
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        valid_i, ready_o, load_i, store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        reg_w_ena_i;
  logic [4:0]  reg_w_addr_i;
  logic [31:0] reg_w_data_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o, ready_i, reg_w_ena_o;
  logic [4:0]  reg_w_addr_o;
  logic [31:0] reg_w_data_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lsu #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .valid_i(valid_i), .ready_o(ready_o),
    .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .reg_w_ena_i(reg_w_ena_i), .reg_w_addr_i(reg_w_addr_i),
    .reg_w_data_i(reg_w_data_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o),
    .ready_i(ready_i), .reg_w_ena_o(reg_w_ena_o), .reg_w_addr_o(reg_w_addr_o),
    .reg_w_data_o(reg_w_data_o), .misalign_o(misalign_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rules: access size in bytes, invalid encodings fall back to a full word.
  function automatic bit f3_bad(input logic [2:0] f3, input bit st);
    if (st) return f3 > 3'd2;
    return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  endfunction

  function automatic int acc_bytes(input logic [2:0] f3, input bit st);
    if (f3_bad(f3, st)) return 4;
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int lane_off(input logic [31:0] a, input int n);
    return (int'(a % 4) / n) * n;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat);
    int n, off;
    longint unsigned v;
    n = acc_bytes(f3, 1'b0);
    off = lane_off(a, n);
    v = 0;
    for (int i = 0; i < n; i++) v |= ((longint'(rdat) >> (8 * (off + i))) & 255) << (8 * i);
    if (!f3[2] && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v |= (64'hFFFF_FFFF << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_be(input int n, input int off);
    int m;
    m = ((1 << n) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int n);
    longint unsigned low, res;
    low = longint'(wd) & ((64'd1 << (8 * n)) - 1);
    res = 0;
    for (int k = 0; k < 4 / n; k++) res |= low << (8 * n * k);
    return res[31:0];
  endfunction

  task automatic mem_op(input bit ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] rdat, input int dly, input int stall,
                        input bit lit, input logic [31:0] lit_val);
    int n;
    bit mis, e_ena;
    logic [31:0] e_addr, e_wd, e_res;
    logic [3:0] e_be;
    n      = acc_bytes(f3, !ld);
    mis    = f3_bad(f3, !ld) || (a % n != 0);
    e_addr = a & ~32'd3;
    e_be   = m_be(n, lane_off(a, n));
    e_wd   = (lit && !ld) ? lit_val : m_wdata(wd, n);
    e_res  = ld ? (lit ? lit_val : m_load(f3, a, rdat)) : 32'd0;
    e_ena  = ld && (rd != 5'd0);

    valid_i = 1'b1; load_i = ld; store_i = !ld; funct3_i = f3; addr_i = a; wdata_i = wd;
    reg_w_ena_i = ld; reg_w_addr_i = rd; reg_w_data_i = $urandom; ready_i = 1'b1;
    #1 chk("mem_accept_ready", ready_o, 1);
    tick();
    valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
    addr_i = $urandom; wdata_i = $urandom; funct3_i = 3'($urandom);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    if (mis) begin
      chk("trap_no_req", dmem_req_o, 0);
      chk("trap_valid", valid_o, 1);
      chk("trap_flag", misalign_o, 1);
      chk("trap_ena", reg_w_ena_o, 0);
      tick();
      chk("trap_retire", valid_o, 0);
      return;
    end
`endif
    chk("bus_req", dmem_req_o, 1);
    chk("bus_we", dmem_we_o, !ld);
    chk("bus_addr", dmem_addr_o, e_addr);
    chk("bus_be", dmem_be_o, e_be);
    if (!ld) chk("bus_wdata", dmem_wdata_o, e_wd);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("bus_hold", {dmem_req_o, dmem_addr_o, dmem_be_o, ready_o, valid_o}, {1'b1, e_addr, e_be, 1'b0, 1'b0});
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = rdat;
    tick();
    dmem_ack_i = 1'b0; dmem_rdata_i = $urandom;
    chk("done_valid", valid_o, 1);
    chk("done_req", dmem_req_o, 0);
    chk("done_ena", reg_w_ena_o, e_ena);
    chk("done_misalign", misalign_o, 0);
    if (ld) begin
      chk("done_data", reg_w_data_o, e_res);
      chk("done_rd", reg_w_addr_o, rd);
    end
    for (int i = 0; i < stall; i++) begin
      ready_i = 1'b0; dmem_ack_i = 1'($urandom);
      tick();
      chk("stall_hold", {valid_o, ready_o, reg_w_ena_o, dmem_req_o}, {1'b1, 1'b0, e_ena, 1'b0});
      if (ld) chk("stall_data", reg_w_data_o, e_res);
    end
    dmem_ack_i = 1'b0; ready_i = 1'b1;
    #1 chk("done_ready_low", ready_o, 0);
    tick();
    chk("retire", valid_o, 0);
    chk("idle_ready", ready_o, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1);
  end

  logic [37:0] q[$];
  logic [2:0]  lf3[5];
  logic [2:0]  sf3[3];
  bit          exp_v, ld;
  logic [2:0]  f3;

  initial begin
    lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    sf3 = '{3'd0, 3'd1, 3'd2};
    arst_n = 1'b0; valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0; funct3_i = '0;
    addr_i = '0; wdata_i = '0; reg_w_ena_i = 1'b0; reg_w_addr_i = '0; reg_w_data_i = '0;
    dmem_ack_i = 1'b0; dmem_rdata_i = '0; ready_i = 1'b1;
    tick(); tick();
    chk("rst_req", dmem_req_o, 0);
    chk("rst_we", dmem_we_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_ena", reg_w_ena_o, 0);
    chk("rst_misalign", misalign_o, 0);
    chk("rst_bus", {dmem_addr_o, dmem_be_o, dmem_wdata_o}, 0);
    chk("rst_wb", {reg_w_addr_o, reg_w_data_o}, 0);
    chk("rst_ready", ready_o, 1);
    arst_n = 1'b1;

    mem_op(1, 3'd0, 32'h1003, $urandom, 5'd5, 32'h80FF_FF12, 0, 0, 1, 32'hFFFF_FF80);
    mem_op(1, 3'd4, 32'h1003, $urandom, 5'd6, 32'h80FF_FF12, 1, 0, 1, 32'h0000_0080);
    mem_op(1, 3'd5, 32'h1002, $urandom, 5'd7, 32'h80FF_FF12, 0, 1, 1, 32'h0000_80FF);
    mem_op(0, 3'd1, 32'h2002, 32'h1234_ABCD, 5'd0, $urandom, 1, 0, 1, 32'hABCD_ABCD);
    mem_op(1, 3'd2, 32'h3004, $urandom, 5'd9, $urandom, 3, 2, 0, 0);
    mem_op(1, 3'd2, 32'h1002, $urandom, 5'd10, 32'hDEAD_BEEF, 0, 0, 0, 0);
    mem_op(1, 3'd3, 32'h1006, $urandom, 5'd11, 32'hCAFE_F00D, 1, 0, 0, 0);
    mem_op(1, 3'd2, 32'h1008, $urandom, 5'd0, 32'h1357_9BDF, 0, 0, 0, 0);

    // Reset while the bus request is outstanding.
    valid_i = 1'b1; load_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h4000;
    reg_w_ena_i = 1'b1; reg_w_addr_i = 5'd7;
    tick();
    valid_i = 1'b0; load_i = 1'b0;
    chk("rstbus_req_before", dmem_req_o, 1);
    arst_n = 1'b0;
    tick();
    chk("rstbus_req", dmem_req_o, 0);
    chk("rstbus_valid", valid_o, 0);
    arst_n = 1'b1;
    valid_i = 1'b1; reg_w_ena_i = 1'b1; reg_w_addr_i = 5'd12; reg_w_data_i = 32'h0BAD_F00D;
    #1 chk("rstbus_ready", ready_o, 1);
    tick();
    valid_i = 1'b0;
    chk("rstbus_alu", {valid_o, reg_w_ena_o, reg_w_addr_o, reg_w_data_o}, {1'b1, 1'b1, 5'd12, 32'h0BAD_F00D});
    tick();
    chk("rstbus_alu_retire", valid_o, 0);

    // ALU stream: the output register holds at most one result.
    q.delete();
    for (int c = 0; c < 300; c++) begin
      valid_i = ($urandom_range(0, 3) != 0); load_i = 1'b0; store_i = 1'b0;
      ready_i = (c < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      reg_w_ena_i = 1'($urandom); reg_w_addr_i = 5'($urandom); reg_w_data_i = $urandom;
      #1;
      exp_v = (q.size() != 0);
      chk("alu_valid", valid_o, exp_v);
      chk("alu_ready", ready_o, !exp_v || ready_i);
      if (exp_v) begin
        chk("alu_result", {reg_w_ena_o, reg_w_addr_o, reg_w_data_o}, q[0]);
        if (ready_i) void'(q.pop_front());
      end
      if (valid_i && (!exp_v || ready_i)) q.push_back({reg_w_ena_i, reg_w_addr_i, reg_w_data_i});
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    #1;
    if (q.size() != 0) chk("alu_last", {reg_w_ena_o, reg_w_addr_o, reg_w_data_o}, q[0]);
    q.delete();
    tick();
    chk("alu_drained", valid_o, 0);

    for (int k = 0; k < 40; k++) begin
      ld = 1'($urandom);
      f3 = ld ? lf3[$urandom_range(0, 4)] : sf3[$urandom_range(0, 2)];
      mem_op(ld, f3, 32'h5000 + 32'($urandom_range(0, 63)), $urandom, 5'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised load/store unit that replaces the pass-through memory stage between EX and WB of the RISC-V pipeline. Drives a request/acknowledge data-memory bus and generates byte enables and store-lane alignment. Sign/zero-extends load data and holds the pipeline with a valid/ready handshake while a bus access is outstanding. Non-memory instructions pass through with one registered cycle.

## Interface
- DATA_W, 32, data/register width; 32 or 64 only (64 enables LD/SD/LWU).
- ADDR_W, 32, byte address width.
- clk  in  1  clock, rising edge.
- arst_n  in  1  reset; synchronous, active-low.
- valid_i  in  1  EX presents an instruction.
- ready_o  out  1  stage accepts the instruction this cycle.
- load_i / store_i  in  1  memory op kind; never both high.
- funct3_i  in  3  RISC-V funct3 of the load/store.
- addr_i  in  ADDR_W  effective byte address.
- wdata_i  in  DATA_W  store data (rs2).
- reg_w_ena_i, reg_w_addr_i[4:0], reg_w_data_i[DATA_W]  in  writeback request from EX (ALU result).
- dmem_req_o  out  1  bus request; dmem_we_o out 1 write; dmem_addr_o out ADDR_W, aligned to DATA_W/8.
- dmem_be_o  out  DATA_W/8  byte enables; dmem_wdata_o out DATA_W lane-aligned store data.
- dmem_ack_i  in  1  access complete; dmem_rdata_i in DATA_W read word.
- valid_o  out  1  result valid toward WB; ready_i in 1 WB accepts.
- reg_w_ena_o, reg_w_addr_o[4:0], reg_w_data_o[DATA_W]  out  writeback to WB.
- misalign_o  out  1  exception flag qualified by valid_o.

## Operation
- FSM: IDLE, BUS, DONE. ready_o = (state==IDLE) && (!valid_o || ready_i).
- IDLE, accept, non-memory: capture reg_w_* into output register, valid_o=1, stay IDLE.
- IDLE, accept, load/store: latch address, byte enables, aligned data, rd; → BUS. Output register cleared when handed off.
- BUS: dmem_req_o=1, all dmem_* stable until dmem_ack_i sampled high; on ack → DONE. Load: formatted dmem_rdata_i loaded into reg_w_data_o. Store: reg_w_ena_o=0.
- DONE: valid_o=1; on ready_i → IDLE. Further input not accepted until then.
- Load format: offset=addr[log2(DATA_W/8)-1:0]. LB/LH/LW/(LD) sign-extend; LBU/LHU/(LWU) zero-extend. Stores replicate low bytes across lanes; be = SB 1 byte, SH 2, SW 4, SD 8, shifted by offset.
- funct3 invalid for DATA_W (e.g. 011 at 32): treated as misaligned.
- Load with rd=x0: bus access performed, reg_w_ena_o=0.

## Timing
- Reset (arst_n low at edge): state IDLE; valid_o, dmem_req_o, dmem_we_o, reg_w_ena_o, misalign_o = 0; all data/address outputs = 0. Reset during BUS abandons the access; req drops the following cycle.
- Non-memory latency 1 cycle; throughput 1/cycle while ready_i=1.
- Load/store: accept T, dmem_req_o from T+1, ack at T+k (k≥1), valid_o at T+k+1.
- valid_o held with stable data until ready_i; ready_i low stalls EX via ready_o.
- dmem_ack_i outside BUS ignored.

## Configuration
- MEM_LSU_MISALIGN_TRAP_EN defined: misaligned access (LH/SH odd, LW/SW not 4-aligned, LD/SD not 8-aligned) or invalid funct3 issues no bus request, goes directly IDLE→DONE with misalign_o=1, reg_w_ena_o=0.
- Undefined: misalign_o tied 0; offset bits below the access size are forced to zero (natural alignment) and the access proceeds; invalid funct3 performs a full-width access.

## Structure
- Shared define file: funct3 encodings (LB..LWU, SB..SD), FSM state encodings, ZERO_WORD, READ_ENABLE/WRITE_ENABLE.
- Sub-module mem_lsu_fmt: combinational store lane alignment, byte-enable generation, load extract/extend, misalignment detect; the top holds FSM and registers.

## Test plan
- Reset mid-BUS: arst_n low while dmem_req_o=1 → next cycle dmem_req_o=0, valid_o=0, then ALU op accepted normally.
- LB at addr 0x1003, rdata 0x80FF_FF12 → reg_w_data_o=0xFFFF_FF80; LBU → 0x0000_0080; LHU at 0x1002 → 0x0000_80FF.
- SH wdata 0x1234_ABCD at 0x2002 → dmem_be_o=4'b1100, dmem_wdata_o=0xABCD_ABCD, dmem_addr_o=0x2000, reg_w_ena_o=0 on retire.
- Ack delayed 3 cycles plus ready_i low 2 cycles → address stable throughout, ready_o low, valid_o held with unchanged data.
- Back-to-back ALU ops with ready_i=1 → one result per cycle, 1-cycle latency, correct rd order.
- LW at 0x1002: with MEM_LSU_MISALIGN_TRAP_EN → no dmem_req_o, misalign_o=1; without → access at 0x1000, misalign_o=0.
